// File: rtl/serial_pack_pkg.sv
// Shared definitions for the serial pack transmitter and receiver:
// FSM state encoding, default pattern geometry and the UART byte width.
package serial_pack_pkg;

    localparam int unsigned UartByteW  = 8;
    localparam int unsigned DefDataBit = 32;
    localparam int unsigned DefPackNum = (DefDataBit / UartByteW) * 2 + 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSend = 3'd1,
        StWait = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4
    } pack_state_e;

    // Bytes needed for two pattern words plus the control byte.
    function automatic int unsigned pack_bytes(input int unsigned data_bit);
        return (data_bit / UartByteW) * 2 + 1;
    endfunction

endpackage

// File: rtl/pack_byte_tx_if.sv
// Client and UART-side signals of the pack transmitter, bundled with
// master (client/testbench) and slave (pack_byte_tx) views.
interface pack_byte_tx_if #(
    parameter int unsigned DATA_BIT = serial_pack_pkg::DefDataBit
) ();
    import serial_pack_pkg::*;

    logic                 i_start;
    logic [DATA_BIT-1:0]  i_output_pattern;
    logic [DATA_BIT-1:0]  i_freq_pattern;
    logic [UartByteW-1:0] i_ctrl;
    logic                 i_tx_done_tick;

    logic                 o_tx_start;
    logic [UartByteW-1:0] o_tx_data;
    logic                 o_busy;
    logic                 o_done_tick;
    logic                 o_err_tick;

    modport master (
        output i_start,
        output i_output_pattern,
        output i_freq_pattern,
        output i_ctrl,
        output i_tx_done_tick,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_done_tick,
        input  o_err_tick
    );

    modport slave (
        input  i_start,
        input  i_output_pattern,
        input  i_freq_pattern,
        input  i_ctrl,
        input  i_tx_done_tick,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_done_tick,
        output o_err_tick
    );

endinterface

// File: rtl/tx_watchdog.sv
// Per-byte completion watchdog: counts enabled cycles, saturating at TIMEOUT_CYC.
// expired flags the cycle whose closing edge brings the count to TIMEOUT_CYC-1.
module tx_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import serial_pack_pkg::*;

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] SatVal = CntW'(TIMEOUT_CYC);
    localparam logic [CntW-1:0] ExpVal = CntW'(TIMEOUT_CYC - 2);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != SatVal)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Looks one edge ahead so the FSM leaves WAIT on the same edge the count lands.
    assign expired = enable && (cnt_q >= ExpVal);

endmodule

// File: rtl/pack_byte_tx.sv
// Sends one pack (output pattern, freq pattern, control byte) byte by byte
// through a UART transmitter, with a per-byte completion watchdog.
module pack_byte_tx #(
    parameter int unsigned DATA_BIT    = serial_pack_pkg::DefDataBit,
    parameter int unsigned PACK_NUM    = serial_pack_pkg::pack_bytes(DATA_BIT),
    parameter int unsigned TIMEOUT_CYC = 100_000
) (
    input logic           clk,
    input logic           rst_n,
    pack_byte_tx_if.slave bus
);
    import serial_pack_pkg::*;

    localparam int unsigned BufW = PACK_NUM * UartByteW;
    localparam int unsigned CntW = $clog2(PACK_NUM);
    localparam logic [CntW-1:0] LastCnt = CntW'(PACK_NUM - 1);

    pack_state_e     state_q;
    logic [BufW-1:0] buf_q;
    logic [CntW-1:0] byte_cnt_q;
    logic            tx_start_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            wd_expired;

    tx_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tx_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == StSend),
        .enable (state_q == StWait),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            byte_cnt_q <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        buf_q      <= BufW'({bus.i_ctrl, bus.i_freq_pattern,
                                             bus.i_output_pattern});
                        byte_cnt_q <= '0;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // A done tick takes priority over a simultaneous watchdog expiry.
                    if (bus.i_tx_done_tick) begin
                        if (byte_cnt_q == LastCnt) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            buf_q      <= buf_q >> UartByteW;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            tx_start_q <= 1'b1;
                            state_q    <= StSend;
                        end
                    end else if (wd_expired) begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end
                end
                StDone, StErr: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_data   = buf_q[UartByteW-1:0];
    assign bus.o_busy      = busy_q;
    assign bus.o_done_tick = done_q;
    assign bus.o_err_tick  = err_q;

    a_byte_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        byte_cnt_q <= LastCnt);
    a_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        tx_start_q |-> busy_q);
    a_single_tick: assert property (@(posedge clk) disable iff (!rst_n)
        !(done_q && err_q));

endmodule

// File: tb/tb_pack_byte_tx.sv
// Directed bench for pack_byte_tx with a small UART responder model.
module tb_pack_byte_tx;

    localparam int unsigned TimeoutCyc = 50;
    localparam int          TieDly     = 48;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pack_byte_tx_if #(.DATA_BIT(32)) bus ();

    pack_byte_tx #(
        .DATA_BIT   (32),
        .TIMEOUT_CYC(TimeoutCyc)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] out_pat;
        logic [31:0] freq_pat;
        logic [7:0]  ctrl;
        int          dly;
        logic [71:0] exp_seq;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    int         uart_delay   = 1;
    int         withhold_idx = -1;
    int         tie_idx      = -1;
    int         pidx         = 0;
    int         n_done       = 0;
    int         n_err        = 0;
    int         done_cyc     = 0;
    int         err_cyc      = 0;
    int         acc_cyc      = 0;
    bit         pend         = 1'b0;
    int         done_at      = 0;

    // UART model: sees o_tx_start, pulses done (delay+1) negedges later.
    initial begin
        bus.i_tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tx_done_tick = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend && cyc == done_at) begin
                    bus.i_tx_done_tick = 1'b1;
                    pend = 1'b0;
                end
                if (bus.o_tx_start) begin
                    got_q.push_back(bus.o_tx_data);
                    start_cyc_q.push_back(cyc);
                    if (pidx != withhold_idx) begin
                        pend    = 1'b1;
                        done_at = cyc + 1 + ((pidx == tie_idx) ? TieDly : uart_delay);
                    end
                    pidx++;
                end
                if (bus.o_done_tick) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (bus.o_err_tick) begin
                    n_err++;
                    err_cyc = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [71:0] pack_got();
        logic [71:0] s;
        s = '0;
        for (int k = 0; k < got_q.size() && k < 9; k++) s[71-8*k -: 8] = got_q[k];
        return s;
    endfunction

    function automatic logic [11:0] out_vec();
        return {bus.o_tx_start, bus.o_tx_data, bus.o_busy, bus.o_done_tick, bus.o_err_tick};
    endfunction

    task automatic reset_sb();
        got_q.delete();
        start_cyc_q.delete();
        pidx         = 0;
        n_done       = 0;
        n_err        = 0;
        withhold_idx = -1;
        tie_idx      = -1;
    endtask

    task automatic send_pack(input logic [31:0] o, input logic [31:0] f, input logic [7:0] c);
        bus.i_output_pattern = o;
        bus.i_freq_pattern   = f;
        bus.i_ctrl           = c;
        bus.i_start          = 1'b1;
        acc_cyc              = cyc + 1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int idle_at);
        int n;
        n = 0;
        idle_at = -1;
        while (bus.o_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_busy) bound_expired(name);
        else idle_at = cyc;
    endtask

    task automatic wait_starts(input string name, input int cnt);
        int n;
        n = 0;
        while (got_q.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() < cnt) bound_expired(name);
    endtask

    task automatic run_vec(input int i);
        int idle_at;
        int sp_bad;
        reset_sb();
        uart_delay = vecs[i].dly;
        send_pack(vecs[i].out_pat, vecs[i].freq_pat, vecs[i].ctrl);
        wait_idle($sformatf("v%0d_idle", i), idle_at);
        check($sformatf("v%0d_nstart", i), got_q.size(), 9);
        check($sformatf("v%0d_bytes", i), pack_got(), vecs[i].exp_seq);
        check($sformatf("v%0d_ndone", i), n_done, 1);
        check($sformatf("v%0d_nerr", i), n_err, 0);
        check($sformatf("v%0d_done_lat", i), done_cyc - acc_cyc, vecs[i].exp_lat);
        check($sformatf("v%0d_first_start", i),
              (start_cyc_q.size() > 0) ? start_cyc_q[0] - acc_cyc : -1, 0);
        sp_bad = 0;
        for (int k = 1; k < start_cyc_q.size(); k++)
            if (start_cyc_q[k] - start_cyc_q[k-1] != vecs[i].dly + 2) sp_bad++;
        check($sformatf("v%0d_spacing_errs", i), sp_bad, 0);
        check($sformatf("v%0d_busy_drop", i), idle_at - done_cyc, 1);
    endtask

    initial begin
        int idle_at;
        int s2;
        int sp;

        vecs[0] = '{out_pat: 32'h1122_3344, freq_pat: 32'hA5A5_0F0F, ctrl: 8'h81, dly: 20,
                    exp_seq: 72'h44_33_22_11_0F_0F_A5_A5_81, exp_lat: 198};
        vecs[1] = '{out_pat: 32'hDEAD_BEEF, freq_pat: 32'h0123_4567, ctrl: 8'h3C, dly: 1,
                    exp_seq: 72'hEF_BE_AD_DE_67_45_23_01_3C, exp_lat: 27};
        vecs[2] = '{out_pat: 32'h0000_0000, freq_pat: 32'hFFFF_FFFF, ctrl: 8'h00, dly: 3,
                    exp_seq: 72'h00_00_00_00_FF_FF_FF_FF_00, exp_lat: 45};
        vecs[3] = '{out_pat: 32'h8000_0001, freq_pat: 32'h7FFF_FFFE, ctrl: 8'hFF, dly: 0,
                    exp_seq: 72'h01_00_00_80_FE_FF_FF_7F_FF, exp_lat: 18};

        rst_n                = 1'b0;
        bus.i_start          = 1'b0;
        bus.i_output_pattern = '0;
        bus.i_freq_pattern   = '0;
        bus.i_ctrl           = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 12'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", out_vec(), 12'h000);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Second start while busy must be dropped.
        reset_sb();
        uart_delay = 3;
        send_pack(vecs[0].out_pat, vecs[0].freq_pat, vecs[0].ctrl);
        wait_starts("busy_wait_b4", 5);
        send_pack(vecs[1].out_pat, vecs[1].freq_pat, vecs[1].ctrl);
        wait_idle("busy_idle", idle_at);
        repeat (40) @(negedge clk);
        check("busy_nstart", got_q.size(), 9);
        check("busy_bytes", pack_got(), vecs[0].exp_seq);
        check("busy_ndone", n_done, 1);
        check("busy_still_idle", bus.o_busy, 1'b0);

        // Withheld done on byte 2: watchdog abort.
        reset_sb();
        uart_delay   = 1;
        withhold_idx = 2;
        send_pack(vecs[0].out_pat, vecs[0].freq_pat, vecs[0].ctrl);
        wait_idle("tmo_idle", idle_at);
        s2 = (start_cyc_q.size() >= 3) ? start_cyc_q[2] : -1000;
        check("tmo_nstart", got_q.size(), 3);
        check("tmo_nerr", n_err, 1);
        check("tmo_ndone", n_done, 0);
        check("tmo_err_lat", err_cyc - s2, 50);
        check("tmo_busy_drop", idle_at - err_cyc, 1);
        run_vec(1);

        // Done tick on the watchdog's last cycle wins.
        reset_sb();
        uart_delay = 1;
        tie_idx    = 3;
        send_pack(vecs[0].out_pat, vecs[0].freq_pat, vecs[0].ctrl);
        wait_idle("tie_idle", idle_at);
        sp = (start_cyc_q.size() >= 5) ? start_cyc_q[4] - start_cyc_q[3] : -1;
        check("tie_nerr", n_err, 0);
        check("tie_ndone", n_done, 1);
        check("tie_bytes", pack_got(), vecs[0].exp_seq);
        check("tie_spacing", sp, TieDly + 2);

        // Reset during byte 6.
        reset_sb();
        uart_delay = 20;
        send_pack(vecs[1].out_pat, vecs[1].freq_pat, vecs[1].ctrl);
        wait_starts("rst_wait_b6", 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_outputs_immediate", out_vec(), 12'h000);
        repeat (3) @(negedge clk);
        check("rst_outputs_held", out_vec(), 12'h000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", n_done, 0);
        check("rst_no_err", n_err, 0);
        check("rst_idle", out_vec(), 12'h000);
        run_vec(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pack_byte_tx.md
PACK_BYTE_TX -- requirements
Module: pack_byte_tx

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 32, giving the width of each pattern word (a multiple of 8).
REQ-002 The block SHALL have parameter PACK_NUM, default (DATA_BIT/8)*2+1, giving the bytes per pack (output pattern + freq pattern + control byte).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 100_000, giving the maximum number of clk cycles to wait for one byte's UART tx completion.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  one-cycle request to send a pack.
REQ-007 i_output_pattern  input  DATA_BIT  output pattern word, sampled when i_start is accepted.
REQ-008 i_freq_pattern  input  DATA_BIT  freq pattern word, sampled when i_start is accepted.
REQ-009 i_ctrl  input  8  control byte, sampled when i_start is accepted.
REQ-010 i_tx_done_tick  input  1  one-cycle completion pulse from the UART transmitter.
REQ-011 o_tx_start  output  1  one-cycle pulse that launches the current byte on the UART transmitter.
REQ-012 o_tx_data  output  8  current byte, driven to the UART transmitter.
REQ-013 o_busy  output  1  high while a pack is in progress.
REQ-014 o_done_tick  output  1  one-cycle pulse when the last byte has completed.
REQ-015 o_err_tick  output  1  one-cycle pulse when a pack is aborted on timeout.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT, DONE and ERR, and SHALL reset to IDLE.
REQ-017 In IDLE, i_start=1 SHALL register all three inputs into a PACK_NUM-byte shift buffer, clear byte_cnt and go to SEND on the next edge.
REQ-018 Byte order on the wire SHALL be: output pattern LSB-first (bytes 0..3), then freq pattern LSB-first (bytes 4..7), then i_ctrl (byte PACK_NUM-1).
REQ-019 In SEND, o_tx_start SHALL be 1 for exactly one cycle, the watchdog SHALL clear, and the FSM SHALL go to WAIT.
REQ-020 o_tx_data SHALL equal the current byte from the SEND cycle until the cycle after the matching i_tx_done_tick, with no glitches.
REQ-021 In WAIT, i_tx_done_tick SHALL do one of two things: if byte_cnt<PACK_NUM-1, shift the buffer one byte, increment byte_cnt and go to SEND; if byte_cnt=PACK_NUM-1, go to DONE.
REQ-022 i_tx_done_tick SHALL be ignored in IDLE, SEND, DONE and ERR.
REQ-023 Latency SHALL be: i_start accepted at edge N gives o_tx_start=1 during cycle N+1; i_tx_done_tick at edge M gives the next o_tx_start during cycle M+1.
REQ-024 DONE SHALL assert o_done_tick for one cycle and then return to IDLE.
REQ-025 A new i_start SHALL be accepted no earlier than the cycle after o_done_tick.
REQ-026 i_start SHALL be ignored whenever o_busy=1, and SHALL neither queue nor corrupt the latched data.
REQ-027 o_busy SHALL be 1 in SEND, WAIT, DONE and ERR, and 0 in IDLE.
REQ-028 The watchdog counter SHALL count clk cycles in WAIT and saturate at TIMEOUT_CYC.
REQ-029 When the watchdog reaches TIMEOUT_CYC-1 with no i_tx_done_tick, the FSM SHALL go to ERR.
REQ-030 If i_tx_done_tick arrives in the same cycle the watchdog reaches TIMEOUT_CYC-1, the done tick SHALL win and no error SHALL be raised.
REQ-031 ERR SHALL assert o_err_tick for one cycle, discard the remaining bytes and return to IDLE.
REQ-032 byte_cnt SHALL be $clog2(PACK_NUM) bits wide and SHALL never exceed PACK_NUM-1.

Reset
REQ-033 rst_n=0 SHALL immediately force the FSM to IDLE, and byte_cnt, the watchdog and the buffer to 0.
REQ-034 During reset all outputs SHALL be 0: o_tx_start, o_tx_data=8'h00, o_busy, o_done_tick, o_err_tick.
REQ-035 Reset mid-pack SHALL abandon the pack without asserting o_done_tick or o_err_tick, and the first i_start after release SHALL start a fresh pack at byte 0.

Structure
REQ-036 The state encoding, DATA_BIT/PACK_NUM defaults and the UART byte width (8) SHALL live in a shared serial_pack_pkg, also used by the pack receiver.
REQ-037 The watchdog SHALL be a sub-module, tx_watchdog, with ports clk, rst_n, clear, enable and expired.

Verification
REQ-038 Normal pack: i_output_pattern=32'h11223344, i_freq_pattern=32'hA5A5_0F0F, i_ctrl=8'h81, UART model returns done 20 cycles after each start -> bytes 44,33,22,11,0F,0F,A5,A5,81 in order, 9 o_tx_start pulses, one o_done_tick.
REQ-039 Immediate done: i_tx_done_tick one cycle after each o_tx_start -> o_tx_start spacing of 3 cycles, and o_done_tick 27 cycles after i_start accepted.
REQ-040 Busy ignore: second i_start with different data during byte 4 -> the first pack is emitted unaltered and no second pack follows.
REQ-041 Timeout: TIMEOUT_CYC=50, withhold the done tick on byte 2 -> o_err_tick exactly 50 cycles after that o_tx_start, o_busy falls next cycle, no o_done_tick; a subsequent pack completes normally.
REQ-042 Boundary tie: done tick on the same cycle the watchdog reaches TIMEOUT_CYC-1 -> no o_err_tick and transmission continues.
REQ-043 Reset mid-pack: rst_n low during byte 6 -> all outputs 0 within the same cycle, no done or error pulse, and the next pack begins with byte 0.
